// File: rtl/bubble_sort_stream_pkg.sv
// Shared definitions for the streaming bubble sorter: FSM state encoding and
// the index-width helper used to size counters.
package bubble_sort_stream_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Bits needed to index 'value' entries; 1 for value <= 2.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bubble_sort_stream_cmp_swap.sv
// Combinational compare-exchange: orders two unsigned values, flags a swap
// only on strict greater-than so equal keys keep their order.
module cmp_swap #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             swap
);

    assign swap = (a > b);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/bubble_sort_stream.sv
// Serial-in, serial-out bubble sorter: loads N elements, sorts in place with one
// compare-swap per clock (early exit on a clean pass), then drains ascending.
module bubble_sort_stream
    import bubble_sort_stream_pkg::*;
#(
    parameter int N     = 5,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int            IW       = clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] LAST_J   = IW'(N - 2);

    state_e                  state_q, state_d;
    logic [N-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [IW-1:0]           wr_idx_q, wr_idx_d;
    logic [IW-1:0]           rd_idx_q, rd_idx_d;
    logic [IW-1:0]           j_q, j_d;
    logic [IW-1:0]           pass_q, pass_d;
    logic                    swapped_q, swapped_d;

    logic [IW-1:0]           j_nxt;
    logic [WIDTH-1:0]        cmp_lo, cmp_hi;
    logic                    swap_now;
    logic                    pass_end;
    logic                    any_swap;

    assign j_nxt    = j_q + IW'(1);
    // Each pass shortens by one: the largest remaining element has settled.
    assign pass_end = (j_q == (LAST_J - pass_q));
    assign any_swap = swapped_q | swap_now;

    cmp_swap #(
        .WIDTH (WIDTH)
    ) u_cmp_swap (
        .a    (mem_q[j_q]),
        .b    (mem_q[j_nxt]),
        .lo   (cmp_lo),
        .hi   (cmp_hi),
        .swap (swap_now)
    );

    // All handshake outputs decode registered state only.
    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_SORT);
    assign out_valid = (state_q == ST_DRAIN);
    assign out_last  = out_valid && (rd_idx_q == LAST_IDX);
    assign out_data  = out_valid ? mem_q[rd_idx_q] : '0;

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        j_d       = j_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    mem_d[wr_idx_q] = in_data;
                    wr_idx_d        = wr_idx_q + IW'(1);
                    if (wr_idx_q == LAST_IDX) begin
                        state_d   = ST_SORT;
                        wr_idx_d  = '0;
                        j_d       = '0;
                        pass_d    = '0;
                        swapped_d = 1'b0;
                    end
                end
            end

            ST_SORT: begin
                mem_d[j_q]   = cmp_lo;
                mem_d[j_nxt] = cmp_hi;
                if (pass_end) begin
                    if (!any_swap || (pass_q == LAST_J)) begin
                        state_d  = ST_DRAIN;
                        rd_idx_d = '0;
                    end else begin
                        pass_d    = pass_q + IW'(1);
                        j_d       = '0;
                        swapped_d = 1'b0;
                    end
                end else begin
                    j_d       = j_nxt;
                    swapped_d = any_swap;
                end
            end

            ST_DRAIN: begin
                if (out_ready) begin
                    rd_idx_d = rd_idx_q + IW'(1);
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = ST_LOAD;
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            j_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            j_q       <= j_d;
            pass_q    <= pass_d;
            swapped_q <= swapped_d;
        end
    end

    // Storage carries no reset; contents are rewritten by every load.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_bubble_sort_stream.sv
// Bench for bubble_sort_stream: directed vector table, a mid-sort reset abort,
// and random batches checked against a sorted-queue / inversion-count model.
module tb_bubble_sort_stream;

    localparam int N     = 5;
    localparam int WIDTH = 8;

    typedef int arr_t [N];

    typedef struct {
        arr_t v;
        arr_t e;
        int   busy;
        bit   gaps;
        bit   bp;
        bit   hold;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    int total;
    int bad;

    bubble_sort_stream #(
        .N     (N),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected SORT cycles: bubble sort needs one pass per step the most
    // displaced element must travel left, plus one clean pass, capped at N-1.
    function automatic int model_busy(input arr_t v);
        int mx, c, p, cyc;
        mx = 0;
        for (int i = 0; i < N; i++) begin
            c = 0;
            for (int k = 0; k < i; k++) if (v[k] > v[i]) c++;
            if (c > mx) mx = c;
        end
        p   = (mx + 1 > N - 1) ? N - 1 : mx + 1;
        cyc = 0;
        for (int q = 0; q < p; q++) cyc += N - 1 - q;
        return cyc;
    endfunction

    function automatic arr_t model_sort(input arr_t v);
        int   q[$];
        arr_t r;
        for (int i = 0; i < N; i++) q.push_back(v[i]);
        q.sort();
        for (int i = 0; i < N; i++) r[i] = q[i];
        return r;
    endfunction

    task automatic load_only(input arr_t vals, input bit gaps, input bit hold_valid);
        int k, cyc;
        bit rdy;
        k   = 0;
        cyc = 0;
        while (k < N && cyc < 300) begin
            @(negedge clk);
            rdy = in_ready;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = 8'(vals[k]);
            end
            @(posedge clk);
            #1;
            if (in_valid && rdy) k++;
            cyc++;
        end
        if (cyc >= 300) check("load_timeout", k, N);
        in_valid = hold_valid;
        in_data  = 8'h5A;
    endtask

    task automatic sort_drain(input arr_t exp, input int exp_busy, input bit bp, input string tag);
        int         cyc, busy_n, got;
        bit         rdy_bad, hold_bad, hold_chk;
        logic [7:0] held_d;
        logic       held_l;
        busy_n  = 0;
        cyc     = 0;
        rdy_bad = 0;
        @(negedge clk);
        while (!out_valid && cyc < 300) begin
            if (in_ready) rdy_bad = 1;
            if (busy) busy_n++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 300) check({tag, "_sort_timeout"}, cyc, 0);
        check({tag, "_busy_cycles"}, busy_n, exp_busy);

        got      = 0;
        cyc      = 0;
        hold_chk = 0;
        hold_bad = 0;
        held_d   = '0;
        held_l   = 1'b0;
        while (got < N && cyc < 300) begin
            if (!out_valid || in_ready || busy) rdy_bad = 1;
            if (hold_chk && (out_data !== held_d || out_last !== held_l)) hold_bad = 1;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) begin
                check($sformatf("%s_data%0d", tag, got), int'(out_data), exp[got]);
                check($sformatf("%s_last%0d", tag, got), int'(out_last), (got == N - 1) ? 1 : 0);
                got++;
                hold_chk = 0;
            end else begin
                held_d   = out_data;
                held_l   = out_last;
                hold_chk = 1;
            end
            cyc++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_drain_count"}, got, N);
        check({tag, "_handshake_flags"}, int'(rdy_bad), 0);
        check({tag, "_hold_stable"}, int'(hold_bad), 0);
        check({tag, "_in_ready_after"}, int'(in_ready), 1);
        check({tag, "_out_valid_after"}, int'(out_valid), 0);
    endtask

    vec_t tbl [5];

    initial begin
        int   n;
        arr_t rv;
        arr_t ab;
        arr_t nb;
        arr_t ne;

        total = 0;
        bad   = 0;

        tbl[0] = '{v: '{30, 10, 50, 20, 40},   e: '{10, 20, 30, 40, 50},   busy: 9,  gaps: 0, bp: 0, hold: 1};
        tbl[1] = '{v: '{1, 2, 3, 4, 5},        e: '{1, 2, 3, 4, 5},        busy: 4,  gaps: 1, bp: 1, hold: 0};
        tbl[2] = '{v: '{50, 40, 30, 20, 10},   e: '{10, 20, 30, 40, 50},   busy: 10, gaps: 0, bp: 1, hold: 0};
        tbl[3] = '{v: '{7, 7, 3, 7, 0},        e: '{0, 3, 7, 7, 7},        busy: 10, gaps: 1, bp: 0, hold: 0};
        tbl[4] = '{v: '{255, 0, 128, 1, 254},  e: '{0, 1, 128, 254, 255},  busy: 9,  gaps: 1, bp: 1, hold: 1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_out_last", int'(out_last), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            load_only(tbl[i].v, tbl[i].gaps, tbl[i].hold);
            sort_drain(tbl[i].e, tbl[i].busy, tbl[i].bp, $sformatf("vec%0d", i));
        end

        // Abort a long sort in its third cycle, then run a fresh batch.
        ab = '{50, 40, 30, 20, 10};
        load_only(ab, 0, 0);
        n = 0;
        for (int c = 0; c < 50 && n < 3; c++) begin
            @(negedge clk);
            if (busy) n++;
        end
        check("abort_reached_sort", n, 3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_out_data", int'(out_data), 0);
        nb = '{9, 8, 7, 6, 5};
        ne = '{5, 6, 7, 8, 9};
        load_only(nb, 0, 0);
        sort_drain(ne, 10, 0, "after_abort");

        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < N; i++) begin
                rv[i] = (b % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
            end
            load_only(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            sort_drain(model_sort(rv), model_busy(rv), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
